// File: rtl/rds_msg_serializer_pkg.sv
// RDS message package: constant message map (20 groups x 13 bytes) and shared
// serializer types. Byte 0 of every group carries the PI high byte 0xCA.
package message;

  localparam int RDS_GRP_BYTES = 13;
  localparam int RDS_NUM_GRPS  = 20;
  localparam int RDS_MSG_BYTES = 260;

  typedef logic [7:0] rds_msg_type;

  localparam rds_msg_type rds_msg_map [RDS_MSG_BYTES] = '{
    8'hCA, 8'hF3, 8'hA0, 8'h00, 8'hD5, 8'h2C, 8'h91, 8'h44, 8'h7E, 8'hB8, 8'h63, 8'h0F, 8'h1A,
    8'hCA, 8'hF3, 8'hA1, 8'h08, 8'h52, 8'h44, 8'h49, 8'h4F, 8'h20, 8'h31, 8'h9C, 8'h77, 8'hE2,
    8'hCA, 8'hF3, 8'hA2, 8'h10, 8'h20, 8'h46, 8'h4D, 8'h20, 8'h2D, 8'h6B, 8'h35, 8'hD1, 8'h08,
    8'hCA, 8'hF3, 8'hA3, 8'h18, 8'h53, 8'h54, 8'h45, 8'h52, 8'h45, 8'h4F, 8'hC4, 8'h2E, 8'h97,
    8'hCA, 8'hF3, 8'h20, 8'h01, 8'h4E, 8'h6F, 8'h77, 8'h20, 8'h70, 8'h6C, 8'h61, 8'h79, 8'h69,
    8'hCA, 8'hF3, 8'h20, 8'h02, 8'h6E, 8'h67, 8'h3A, 8'h20, 8'h54, 8'h68, 8'h65, 8'h20, 8'h51,
    8'hCA, 8'hF3, 8'h20, 8'h03, 8'h75, 8'h69, 8'h65, 8'h74, 8'h20, 8'h48, 8'h6F, 8'h75, 8'h72,
    8'hCA, 8'hF3, 8'h20, 8'h04, 8'h20, 8'h2D, 8'h20, 8'h4C, 8'h69, 8'h76, 8'h65, 8'h20, 8'h21,
    8'hCA, 8'hF3, 8'h40, 8'h00, 8'h3B, 8'h8E, 8'hC2, 8'h19, 8'h05, 8'hFF, 8'h80, 8'h7F, 8'h55,
    8'hCA, 8'hF3, 8'h41, 8'h00, 8'hAA, 8'h33, 8'hCC, 8'h0C, 8'hF0, 8'h96, 8'h69, 8'hE1, 8'h1E,
    8'hCA, 8'hF3, 8'hA0, 8'h05, 8'hD9, 8'h42, 8'h6E, 8'hB3, 8'h27, 8'h8A, 8'h15, 8'hC0, 8'h3F,
    8'hCA, 8'hF3, 8'hA1, 8'h0D, 8'h4B, 8'h58, 8'h59, 8'h5A, 8'h2D, 8'h46, 8'h4D, 8'h01, 8'hFE,
    8'hCA, 8'hF3, 8'hA2, 8'h15, 8'h7C, 8'h83, 8'h2A, 8'hD5, 8'h66, 8'h99, 8'h12, 8'hED, 8'h48,
    8'hCA, 8'hF3, 8'hA3, 8'h1D, 8'hB7, 8'h04, 8'h6A, 8'h93, 8'h3C, 8'hC3, 8'h5E, 8'hA1, 8'h70,
    8'hCA, 8'hF3, 8'h20, 8'h05, 8'h4E, 8'h65, 8'h77, 8'h73, 8'h20, 8'h61, 8'h74, 8'h20, 8'h39,
    8'hCA, 8'hF3, 8'h20, 8'h06, 8'h20, 8'h61, 8'h6E, 8'h64, 8'h20, 8'h6D, 8'h69, 8'h64, 8'h6E,
    8'hCA, 8'hF3, 8'h20, 8'h07, 8'h69, 8'h67, 8'h68, 8'h74, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20,
    8'hCA, 8'hF3, 8'h40, 8'h01, 8'hC8, 8'h37, 8'h5B, 8'hA4, 8'h0E, 8'hF1, 8'h62, 8'h9D, 8'h2B,
    8'hCA, 8'hF3, 8'hE0, 8'h00, 8'h81, 8'h7E, 8'h3D, 8'hC2, 8'h54, 8'hAB, 8'h06, 8'hF9, 8'h47,
    8'hCA, 8'hF3, 8'hE1, 8'h00, 8'h18, 8'hE7, 8'h92, 8'h6D, 8'hB5, 8'h4A, 8'h2F, 8'hD0, 8'h8C
  };

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } rds_ser_state_e;

endpackage

// File: rtl/rds_diff_enc.sv
// RDS differential encoder: enc_bit = raw_bit ^ previous transmitted bit; the
// transmitted bit is captured on each accept strobe, sync clear has priority.
module rds_diff_enc (
  input  logic clk,
  input  logic arst_n,
  input  logic clr,
  input  logic acc,
  input  logic raw_bit,
  output logic enc_bit
);

  logic prev_q, prev_d;

  assign enc_bit = raw_bit ^ prev_q;

  always_comb begin
    prev_d = prev_q;
    if (clr) begin
      prev_d = 1'b0;
    end else if (acc) begin
      prev_d = enc_bit;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
    end
  end

endmodule

// File: rtl/rds_msg_serializer.sv
// Streams message::rds_msg_map MSB-first over a valid/ready handshake, looping forever.
// Optional differential encoding is built when RDS_DIFF_EN is defined.
module rds_msg_serializer
  import message::*;
#(
  parameter int MSG_BYTES = RDS_MSG_BYTES,
  parameter int GRP_BYTES = RDS_GRP_BYTES,
  parameter int NUM_GRPS  = RDS_NUM_GRPS
) (
  input  logic       clk,
  input  logic       arst_n,
  input  logic       en,
  input  logic       restart,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_bit,
  output logic       grp_start,
  output logic [4:0] grp_idx
);

  localparam int ADDR_W = $clog2(MSG_BYTES);
  localparam int BIG_W  = $clog2(GRP_BYTES);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(MSG_BYTES - 1);
  localparam logic [BIG_W-1:0]  BIG_LAST  = BIG_W'(GRP_BYTES - 1);
  localparam logic [4:0]        GRP_LAST  = 5'(NUM_GRPS - 1);

  if (MSG_BYTES != GRP_BYTES * NUM_GRPS) begin : g_bad_cfg
    $error("rds_msg_serializer: MSG_BYTES must equal GRP_BYTES*NUM_GRPS");
  end

  rds_ser_state_e    state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, addr_nxt;
  logic [BIG_W-1:0]  byte_in_grp_q, byte_in_grp_d;
  logic [4:0]        grp_idx_q, grp_idx_d;
  logic [2:0]        bit_ptr_q, bit_ptr_d;
  rds_msg_type       shifter_q, shifter_d;
  logic              accept;
  logic              raw_bit;
  logic              enc_bit;

  assign accept   = (state_q == ST_RUN) && out_ready;
  assign raw_bit  = shifter_q[bit_ptr_q];
  assign addr_nxt = (addr_q == ADDR_LAST) ? '0 : addr_q + 1'b1;

  // Restart outranks everything, including an accept in the same cycle.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    byte_in_grp_d = byte_in_grp_q;
    grp_idx_d     = grp_idx_q;
    bit_ptr_d     = bit_ptr_q;
    shifter_d     = shifter_q;
    if (restart) begin
      state_d       = ST_IDLE;
      addr_d        = '0;
      byte_in_grp_d = '0;
      grp_idx_d     = '0;
      bit_ptr_d     = 3'd7;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (en) begin
            state_d   = ST_RUN;
            shifter_d = rds_msg_map[addr_q];
          end
        end
        ST_RUN: begin
          if (accept) begin
            if (!en) begin
              state_d = ST_IDLE;
            end
            if (bit_ptr_q == 3'd0) begin
              // Next byte loads in the same cycle so the stream has no bubble.
              bit_ptr_d = 3'd7;
              addr_d    = addr_nxt;
              shifter_d = rds_msg_map[addr_nxt];
              if (byte_in_grp_q == BIG_LAST) begin
                byte_in_grp_d = '0;
                grp_idx_d     = (grp_idx_q == GRP_LAST) ? 5'd0 : grp_idx_q + 5'd1;
              end else begin
                byte_in_grp_d = byte_in_grp_q + 1'b1;
              end
            end else begin
              bit_ptr_d = bit_ptr_q - 3'd1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      byte_in_grp_q <= '0;
      grp_idx_q     <= '0;
      bit_ptr_q     <= 3'd7;
      shifter_q     <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      byte_in_grp_q <= byte_in_grp_d;
      grp_idx_q     <= grp_idx_d;
      bit_ptr_q     <= bit_ptr_d;
      shifter_q     <= shifter_d;
    end
  end

`ifdef RDS_DIFF_EN
  rds_diff_enc u_diff_enc (
    .clk     (clk),
    .arst_n  (arst_n),
    .clr     (restart),
    .acc     (accept),
    .raw_bit (raw_bit),
    .enc_bit (enc_bit)
  );
`else
  assign enc_bit = raw_bit;
`endif

  assign out_valid = (state_q == ST_RUN);
  assign out_bit   = out_valid & enc_bit;
  assign grp_start = out_valid && (byte_in_grp_q == '0) && (bit_ptr_q == 3'd7);
  assign grp_idx   = grp_idx_q;

endmodule
